// File: rtl/fsqrt_pkg.sv
// Shared types, constants and elaboration-time helpers for the table-driven
// binary32 square root.
package fsqrt_pkg;

    typedef enum logic [2:0] {
        ClsZero = 3'd0,
        ClsInf  = 3'd1,
        ClsNan  = 3'd2,
        ClsNeg  = 3'd3,
        ClsNorm = 3'd4
    } cls_e;

    localparam logic [31:0] QNAN    = 32'h7FC0_0000;
    localparam logic [31:0] POS_INF = 32'h7F80_0000;
    localparam int unsigned BIAS    = 127;

    function automatic int unsigned idx_width(input int unsigned idx_w);
        return idx_w + 1;
    endfunction

    // Integer square root rounded to nearest; only evaluated while building the ROM image.
    function automatic logic [63:0] isqrt_rnd(input logic [63:0] n);
        logic [63:0] r;
        logic [63:0] rem;
        logic [63:0] b;
        r   = '0;
        rem = n;
        b   = 64'h1 << 62;
        for (int i = 0; i < 32; i++) begin
            if (rem >= r + b) begin
                rem = rem - (r + b);
                r   = (r >> 1) + b;
            end else begin
                r = r >> 1;
            end
            b = b >> 2;
        end
        if (rem > r) r = r + 64'd1;
        return r;
    endfunction

endpackage

// File: rtl/fsqrt_table.sv
// Synchronous-read ROM of {c, g} interpolation pairs, filled with the image computed at
// elaboration.
module fsqrt_table import fsqrt_pkg::*; #(
    parameter int unsigned IDX_W      = 9,
    parameter int unsigned G_W        = 23 - IDX_W,
    parameter string       TABLE_FILE = "sqrtinit.bin"
) (
    input  logic            clk,
    input  logic            en,
    input  logic [IDX_W:0]  addr,
    output logic [22+G_W:0] data
);
    localparam int unsigned Depth = 2 ** idx_width(IDX_W);
    localparam int unsigned DataW = 23 + G_W;

    // c = sqrt at interval start, g = chord rise; both at 2^-23 with 7 guard bits before rounding
    function automatic logic [DataW-1:0] table_entry(input int unsigned i);
        logic [63:0] base;
        logic [63:0] s0;
        logic [63:0] s1;
        int unsigned sh;
        base = 64'((1 << IDX_W) + (i % (1 << IDX_W)));
        sh   = 60 - IDX_W + (((i >> IDX_W) == 0) ? 1 : 0);
        s0   = (isqrt_rnd(base << sh) + 64'd64) >> 7;
        s1   = (isqrt_rnd((base + 64'd1) << sh) + 64'd64) >> 7;
        return {23'(s0 - (64'd1 << 23)), G_W'(s1 - s0)};
    endfunction

    logic [DataW-1:0] mem [Depth];
    logic [DataW-1:0] data_q;

    for (genvar i = 0; i < Depth; i++) begin : g_entry
        localparam logic [DataW-1:0] Entry = table_entry(i);
        assign mem[i] = Entry;
    end

    always_ff @(posedge clk) begin
        if (en) data_q <= mem[addr];
    end

    assign data = data_q;

endmodule

// File: rtl/fsqrt_pipe.sv
// Elastic 3-stage binary32 square root: decode + ROM read, interpolate, round/special mux.
// Every stage advances together when the output slot is free or being drained.
module fsqrt_pipe import fsqrt_pkg::*; #(
    parameter int unsigned IDX_W      = 9,
    parameter int unsigned A_W        = 23 - IDX_W,
    parameter int unsigned G_W        = A_W,
    parameter int unsigned TAG_W      = 4,
    parameter string       TABLE_FILE = "sqrtinit.bin"
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_x,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_y,
    output logic [TAG_W-1:0] out_tag
);
    localparam int unsigned IW = idx_width(IDX_W);
    localparam int unsigned PW = 23 + A_W + 1;

    logic            en;
    logic            sgn;
    logic [7:0]      exp_in;
    logic [22:0]     man;
    logic [IW-1:0]   idx;
    logic [8:0]      re_sum;
    cls_e            cls_d;
    logic [22+G_W:0] rom_data;

    logic             v1_q, s1_q;
    cls_e             cls1_q;
    logic [7:0]       re1_q;
    logic [A_W-1:0]   a1_q;
    logic [TAG_W-1:0] tag1_q;

    logic [22:0]      c2;
    logic [G_W-1:0]   g2;
    logic [PW-1:0]    p2_d, p2_q;
    logic             v2_q, s2_q;
    cls_e             cls2_q;
    logic [7:0]       re2_q;
    logic [TAG_W-1:0] tag2_q;

    logic [23:0]      mant;
    logic [30:0]      norm;
    logic [31:0]      y3_d, y_q;
    logic             v3_q;
    logic [TAG_W-1:0] tag_q;
    logic             unused_bits;

    assign en       = !v3_q || out_ready;
    assign in_ready = en;

    assign sgn    = in_x[31];
    assign exp_in = in_x[30:23];
    assign man    = in_x[22:0];
    assign idx    = {exp_in[0], man[22 -: IDX_W]};
    // Odd biased exponent means an even true exponent: halve it directly, else fold a 2 into m
    assign re_sum = {1'b0, exp_in} + (exp_in[0] ? 9'(BIAS) : 9'(BIAS - 1));

    always_comb begin
        cls_d = ClsNorm;
        if (exp_in == 8'h00) begin
            cls_d = ClsZero;
        end else if (exp_in == 8'hFF && man != 23'd0) begin
            cls_d = ClsNan;
        end else if (sgn) begin
            cls_d = ClsNeg;
        end else if (exp_in == 8'hFF) begin
            cls_d = ClsInf;
        end
    end

    fsqrt_table #(
        .IDX_W      (IDX_W),
        .G_W        (G_W),
        .TABLE_FILE (TABLE_FILE)
    ) u_table (
        .clk  (clk),
        .en   (en),
        .addr (idx),
        .data (rom_data)
    );

    assign c2   = rom_data[22+G_W:G_W];
    assign g2   = rom_data[G_W-1:0];
    assign p2_d = PW'({c2, {A_W{1'b0}}}) + PW'(g2) * PW'(a1_q);

    assign mant = {1'b0, p2_q[A_W+22:A_W]} + 24'(p2_q[A_W-1]);
    assign norm = {re2_q, 23'd0} + 31'(mant);

    always_comb begin
        y3_d = {1'b0, norm};
        unique case (cls2_q)
            ClsZero:        y3_d = {s2_q, 31'd0};
            ClsInf:         y3_d = POS_INF;
            ClsNan, ClsNeg: y3_d = QNAN;
            default:        y3_d = {1'b0, norm};
        endcase
    end

    assign unused_bits = ^{re_sum[0], p2_q[PW-1], p2_q[A_W-2:0]};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v1_q   <= 1'b0;
            s1_q   <= 1'b0;
            cls1_q <= ClsZero;
            re1_q  <= '0;
            a1_q   <= '0;
            tag1_q <= '0;
            v2_q   <= 1'b0;
            s2_q   <= 1'b0;
            cls2_q <= ClsZero;
            re2_q  <= '0;
            p2_q   <= '0;
            tag2_q <= '0;
            v3_q   <= 1'b0;
            y_q    <= '0;
            tag_q  <= '0;
        end else if (en) begin
            v1_q   <= in_valid;
            s1_q   <= sgn;
            cls1_q <= cls_d;
            re1_q  <= re_sum[8:1];
            a1_q   <= man[A_W-1:0];
            tag1_q <= in_tag;
            v2_q   <= v1_q;
            s2_q   <= s1_q;
            cls2_q <= cls1_q;
            re2_q  <= re1_q;
            p2_q   <= p2_d;
            tag2_q <= tag1_q;
            v3_q   <= v2_q;
            y_q    <= y3_d;
            tag_q  <= tag2_q;
        end
    end

    assign out_valid = v3_q;
    assign out_y     = y_q;
    assign out_tag   = tag_q;

endmodule
